// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared types and lane constants for the load/store unit.
// Revision : 1.0
// ============================================================================
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } lsuState_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [31:0] C_BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] C_HALF_MASK = 32'h0000_FFFF;

  // Bit position of the lowest bit of byte lane 'off' (little-endian).
  function automatic logic [4:0] laneShift(input logic [1:0] off);
    return {off, 3'b000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_byte_lane.sv
`default_nettype none
// ============================================================================
// Module   : lsu_byte_lane
// Brief    : Combinational load extraction/extension and sub-word store merge.
// Revision : 1.0
// ============================================================================
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] i_memWord,
  input  logic [31:0] i_storeData,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_signExt,
  output logic [31:0] o_loadVal,
  output logic [31:0] o_mergeWord
);

  logic [4:0]  w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_mask;
  logic [31:0] w_lane;

  always_comb begin
    w_shift     = laneShift(i_offset);
    w_byte      = i_memWord[{i_offset, 3'b000} +: 8];
    w_half      = i_memWord[{i_offset[1], 4'b0000} +: 16];
    o_loadVal   = i_memWord;
    w_mask      = 32'hFFFF_FFFF;
    w_lane      = i_storeData;
    case (i_size)
      SZ_HALF: begin
        o_loadVal = {{16{i_signExt & w_half[15]}}, w_half};
        w_mask    = C_HALF_MASK << w_shift;
        w_lane    = (i_storeData & C_HALF_MASK) << w_shift;
      end
      SZ_BYTE: begin
        o_loadVal = {{24{i_signExt & w_byte[7]}}, w_byte};
        w_mask    = C_BYTE_MASK << w_shift;
        w_lane    = (i_storeData & C_BYTE_MASK) << w_shift;
      end
      default: ;
    endcase
    o_mergeWord = (i_memWord & ~w_mask) | w_lane;
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_port
// Brief    : Load/store unit in front of a word-wide memory with fixed read
//            latency; read-modify-write for sub-word stores.
//            Option: LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses.
// Revision : 1.0
// ============================================================================
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  lsuState_t        r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_isStore;
  logic [1:0]       r_size;
  logic [1:0]       r_offset;
  logic             r_signExt;

  logic [1:0]       w_reqSize;
  logic [1:0]       w_reqOffset;
  logic             w_trapNow;
  logic [31:0]      w_loadVal;
  logic [31:0]      w_mergeWord;

  always_comb begin
    w_reqSize   = (size == SZ_HALF || size == SZ_BYTE) ? size : SZ_WORD;
    w_reqOffset = addr[1:0];
    if (w_reqSize == SZ_HALF) w_reqOffset = {addr[1], 1'b0};
    if (w_reqSize == SZ_WORD) w_reqOffset = 2'b00;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_trap;
  assign w_trapNow = ((w_reqSize == SZ_HALF) && addr[0]) ||
                     ((w_reqSize == SZ_WORD) && (addr[1:0] != 2'b00));
  assign misalign  = (r_state == ST_DONE) && r_trap;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                     r_trap <= 1'b0;
    else if (r_state == ST_IDLE && req) r_trap <= w_trapNow;
  end
`else
  assign w_trapNow = 1'b0;
  assign misalign  = 1'b0;
`endif

  // Store data for sub-word stores waits in mem_wdata until the merge.
  lsu_byte_lane u_lane (
    .i_memWord   (mem_rdata),
    .i_storeData (mem_wdata),
    .i_size      (r_size),
    .i_offset    (r_offset),
    .i_signExt   (r_signExt),
    .o_loadVal   (w_loadVal),
    .o_mergeWord (w_mergeWord)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          if (w_trapNow)                        w_next = ST_DONE;
          else if (we && w_reqSize == SZ_WORD) w_next = ST_WRITE;
          else                                  w_next = ST_READ;
        end
      end
      ST_READ:  if (r_cnt == '0) w_next = r_isStore ? ST_WRITE : ST_DONE;
      ST_WRITE: w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_isStore <= 1'b0;
      r_size    <= SZ_WORD;
      r_offset  <= 2'b00;
      r_signExt <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_cnt     <= C_CNT_LOAD;
            r_isStore <= we;
            r_size    <= w_reqSize;
            r_offset  <= w_reqOffset;
            r_signExt <= sign_ext;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= wdata;
          end
        end
        ST_READ: begin
          if (r_cnt != '0)    r_cnt     <= r_cnt - 1'b1;
          else if (r_isStore) mem_wdata <= w_mergeWord;
          else                rdata     <= w_loadVal;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != ST_IDLE);
  assign done   = (r_state == ST_DONE);
  assign mem_wr = (r_state == ST_WRITE);

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_port
// Brief    : Directed self-checking bench for lsu_mem_port with a 2-cycle
//            latency memory model.
// Revision : 1.0
// ============================================================================
module tb_lsu_mem_port;
  import lsu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = SZ_WORD;
  logic [31:0] addr = '0, wdata = '0;
  logic        busy, done, misalign, mem_wr;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];
  logic [31:0] rdq;
  logic        doInit = 1'b1;

  int nTotal = 0;
  int nBad   = 0;

  lsu_mem_port #(.MEM_LATENCY(2)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .rdata(rdata), .misalign(misalign), .mem_addr(mem_addr),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // One register stage after address gives data valid two edges later.
  always @(posedge clock) begin
    if (doInit) begin
      mem[64] <= 32'h80FF_7F01;
      mem[65] <= 32'h0000_0000;
      mem[66] <= 32'h0000_0000;
    end else if (mem_wr) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
    rdq <= mem[mem_addr[9:2]];
  end
  assign mem_rdata = rdq;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTotal++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic doTxn(input logic iWe, input logic [1:0] iSize, input logic iSext,
                       input logic [31:0] iAddr, input logic [31:0] iWdata, input bit poke,
                       output int doneAt, output int wrAt, output int wrCnt, output logic misal);
    @(negedge clock);
    req = 1'b1; we = iWe; size = iSize; sign_ext = iSext; addr = iAddr; wdata = iWdata;
    @(posedge clock); #1;
    req = 1'b0; we = ~iWe; sign_ext = ~iSext; addr = 32'h0000_03FC; wdata = ~iWdata;
    doneAt = -1; wrAt = -1; wrCnt = 0; misal = 1'b0;
    for (int k = 1; k <= 20 && doneAt < 0; k++) begin
      if (poke && k == 1) begin
        req = 1'b1; we = 1'b1; size = SZ_WORD; addr = 32'h108; wdata = 32'hDEAD_BEEF;
      end
      if (poke && k == 2) req = 1'b0;
      if (mem_wr) begin wrCnt++; wrAt = k; end
      if (done) begin doneAt = k; misal = misalign; end
      if (doneAt < 0) begin @(posedge clock); #1; end
    end
    req = 1'b0;
    @(posedge clock); #1;
  endtask

  int   dAt, wAt, wCnt;
  logic mis;

  initial begin
    #12;
    checkVal("rst_busy", {31'b0, busy}, 32'd0);
    checkVal("rst_done", {31'b0, done}, 32'd0);
    checkVal("rst_memwr", {31'b0, mem_wr}, 32'd0);
    checkVal("rst_misal", {31'b0, misalign}, 32'd0);
    checkVal("rst_rdata", rdata, 32'd0);
    checkVal("rst_maddr", mem_addr, 32'd0);
    checkVal("rst_mwdata", mem_wdata, 32'd0);
    @(negedge clock); reset = 1'b1;
    @(negedge clock); doInit = 1'b0;

    doTxn(1'b0, SZ_BYTE, 1'b1, 32'h103, 32'h0, 1'b0, dAt, wAt, wCnt, mis);
    checkVal("lb_s103", rdata, 32'hFFFF_FF80);
    checkVal("lb_done_at", dAt, 32'd3);
    checkVal("lb_wr_cnt", wCnt, 32'd0);

    doTxn(1'b0, SZ_HALF, 1'b0, 32'h102, 32'h0, 1'b0, dAt, wAt, wCnt, mis);
    checkVal("lhu_102", rdata, 32'h0000_80FF);
    doTxn(1'b0, SZ_HALF, 1'b1, 32'h102, 32'h0, 1'b0, dAt, wAt, wCnt, mis);
    checkVal("lh_102", rdata, 32'hFFFF_80FF);

    doTxn(1'b1, SZ_BYTE, 1'b0, 32'h101, 32'h0000_00AB, 1'b0, dAt, wAt, wCnt, mis);
    checkVal("sb_mem", mem[64], 32'h80FF_AB01);
    checkVal("sb_wr_cnt", wCnt, 32'd1);
    checkVal("sb_wr_at", wAt, 32'd3);
    checkVal("sb_done_at", dAt, 32'd4);
    checkVal("sb_rdata_hold", rdata, 32'hFFFF_80FF);

    doTxn(1'b0, SZ_BYTE, 1'b1, 32'h101, 32'h0, 1'b0, dAt, wAt, wCnt, mis);
    checkVal("lb_s101", rdata, 32'hFFFF_FFAB);

    doTxn(1'b1, SZ_WORD, 1'b0, 32'h104, 32'h1234_5678, 1'b1, dAt, wAt, wCnt, mis);
    checkVal("sw_mem", mem[65], 32'h1234_5678);
    checkVal("sw_wr_at", wAt, 32'd1);
    checkVal("sw_wr_cnt", wCnt, 32'd1);
    checkVal("sw_done_at", dAt, 32'd2);
    checkVal("sw_idle", {31'b0, busy}, 32'd0);
    @(posedge clock); #1;
    checkVal("sw_req_dropped", {31'b0, busy}, 32'd0);
    checkVal("sw_mem_poke", mem[66], 32'd0);

    doTxn(1'b1, SZ_HALF, 1'b0, 32'h106, 32'h0000_BEEF, 1'b0, dAt, wAt, wCnt, mis);
    checkVal("sh_mem", mem[65], 32'hBEEF_5678);
    checkVal("sh_done_at", dAt, 32'd4);

    doTxn(1'b0, 2'b11, 1'b1, 32'h104, 32'h0, 1'b0, dAt, wAt, wCnt, mis);
    checkVal("lw_rsvd", rdata, 32'hBEEF_5678);
    checkVal("lw_done_at", dAt, 32'd3);

    doTxn(1'b1, SZ_BYTE, 1'b0, 32'h101, 32'h0000_007F, 1'b0, dAt, wAt, wCnt, mis);
    checkVal("sb_restore", mem[64], 32'h80FF_7F01);

    doTxn(1'b0, SZ_HALF, 1'b0, 32'h101, 32'h0, 1'b0, dAt, wAt, wCnt, mis);
`ifdef LSU_MISALIGN_TRAP_EN
    checkVal("mis_done_at", dAt, 32'd1);
    checkVal("mis_flag", {31'b0, mis}, 32'd1);
    checkVal("mis_rdata", rdata, 32'hBEEF_5678);
    checkVal("mis_wr_cnt", wCnt, 32'd0);
`else
    checkVal("mis_done_at", dAt, 32'd3);
    checkVal("mis_flag", {31'b0, mis}, 32'd0);
    checkVal("mis_rdata", rdata, 32'h0000_7F01);
`endif

    @(negedge clock);
    req = 1'b1; we = 1'b1; size = SZ_BYTE; sign_ext = 1'b0; addr = 32'h101; wdata = 32'h0000_00CD;
    @(posedge clock); #1;
    req = 1'b0;
    checkVal("ar_busy_pre", {31'b0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    checkVal("ar_busy", {31'b0, busy}, 32'd0);
    checkVal("ar_done", {31'b0, done}, 32'd0);
    checkVal("ar_memwr", {31'b0, mem_wr}, 32'd0);
    checkVal("ar_rdata", rdata, 32'd0);
    checkVal("ar_maddr", mem_addr, 32'd0);
    checkVal("ar_mwdata", mem_wdata, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checkVal("ar_mem_kept", mem[64], 32'h80FF_7F01);
    checkVal("ar_idle", {31'b0, busy}, 32'd0);

    doTxn(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 1'b0, dAt, wAt, wCnt, mis);
    checkVal("lw_after_rst", rdata, 32'h80FF_7F01);
    checkVal("lw_after_rst_at", dAt, 32'd3);

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit between the multicycle CPU datapath and the word-wide `Memoria` block. It accepts one load or store request per transaction (word, halfword or byte, signed or unsigned loads) and waits out the memory read latency. It performs read-modify-write for sub-word stores, because memory writes whole words only. It returns aligned, extended load data with a one-cycle `done` pulse, so the control unit no longer counts memory wait states.

## Interface
- `MEM_LATENCY`, 2: cycles from `mem_addr` valid to `mem_rdata` valid; legal range ≥1.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  request strobe; sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word).
- `sign_ext`  in  1  loads only: 1 sign-extends, 0 zero-extends.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; half in [15:0], byte in [7:0].
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  extended load result; holds until the next load completes.
- `misalign`  out  1  pulses together with `done` on a trapped misaligned access.
- `mem_addr`  out  32  word address to memory, with [1:0] = 0.
- `mem_wr`  out  1  memory write enable.
- `mem_wdata`  out  32  word written to memory.
- `mem_rdata`  in  32  memory read data.

## Operation
- Byte order is little-endian: byte lane k = addr[1:0] occupies bits [8k+7:8k]; half lane = addr[1].
- On the IDLE edge where `req` = 1, the unit latches `we`, `size`, `sign_ext`, `addr` and `wdata`. Input changes after acceptance are ignored. A `req` outside IDLE is dropped, not queued.
- States: IDLE, READ, WRITE, DONE.
  - IDLE → READ for a load or a sub-word store.
  - IDLE → WRITE for a word store.
  - IDLE → DONE for a trapped misaligned access.
  - READ holds for MEM_LATENCY cycles, using a down-counter loaded with MEM_LATENCY-1. On exit, a load goes to DONE with `rdata` captured. A sub-word store goes to WRITE, with the merged word registered into `mem_wdata`.
  - WRITE lasts 1 cycle, then goes to DONE.
  - DONE lasts 1 cycle, then returns to IDLE.
- Loads: lane extraction followed by sign or zero extension to 32 bits. A word load passes the data through.
- Sub-word stores replace only the target lane of the read word. All other bits are preserved.
- `mem_wr` is decoded directly from the state register (high only in WRITE), so reset removes it asynchronously.
- `mem_addr` = {latched addr[31:2], 2'b00}. It is stable from the acceptance edge through DONE.

## Timing
- `done` cycle, counted as cycles after the acceptance edge:
  - load: MEM_LATENCY+1
  - word store: 2
  - sub-word store: MEM_LATENCY+2
  - trapped misaligned access: 1
- `mem_wr` is high for exactly one cycle per store, in the cycle just before `done`.
- Back-to-back requests need at least one IDLE cycle. The earliest new acceptance is the edge after DONE.
- Reset values: `busy`, `done`, `misalign`, `mem_wr` = 0; `rdata`, `mem_addr`, `mem_wdata` = 0; state = IDLE; counter = 0.
- Reset asserted mid-transaction: the transaction is abandoned immediately. There is no `done` and no memory write, even in READ of a sub-word store.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a half access with addr[0] = 1, or a word access with addr[1:0] ≠ 0, makes no memory access. `done` and `misalign` pulse 1 cycle after acceptance, and `rdata` is unchanged.
- `LSU_MISALIGN_TRAP_EN` undefined: `misalign` is tied to 0. Offending low address bits are forced to zero (half: addr[0]; word: addr[1:0]), and the access proceeds normally.

## Structure
- `lsu_pkg` holds the state enum, the size encodings (SZ_WORD, SZ_HALF, SZ_BYTE) and the lane-select helper constants.
- Sub-module `lsu_byte_lane` is purely combinational and covers:
  - extract and extend: mem word, size, offset, sign → load value;
  - merge: mem word, store data, size, offset → write word.
- The top level holds the FSM, the counter and the registers.

## Test plan
- Memory [0x100] = 0x80FF7F01, signed byte load at 0x103 → `rdata` = 0xFFFFFF80, with `done` exactly MEM_LATENCY+1 (3) cycles after acceptance and `mem_wr` never high.
- Unsigned half load at 0x102, same word → `rdata` = 0x000080FF. Signed half load at 0x102 → 0xFFFF80FF.
- Byte store with `wdata` = 0x000000AB at 0x101 → memory [0x100] = 0x80FFAB01, one `mem_wr` pulse, `done` 4 cycles after acceptance.
- Word store 0x12345678 at 0x104 → no READ state, `mem_wr` at acceptance+1, `done` at +2, memory [0x104] = 0x12345678. A `req` pulsed while `busy` is ignored.
- Half load at 0x101:
  - with `LSU_MISALIGN_TRAP_EN`: `misalign` and `done` at +1, no memory access;
  - without it: `rdata` = 0x00007F01 (unsigned), `misalign` = 0.
- `reset` driven low during READ of a byte store → all outputs 0 immediately and memory [0x100] unchanged. After release, a word load at 0x100 completes normally with 0x80FF7F01.
